// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, default timing and frame format.
// The transmit side uses the same bit period and frame constants.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 10;
   localparam int DATA_BITS_DEF    = 8;
   localparam int SYNC_STAGES      = 2;
   localparam logic IDLE_LEVEL     = 1'b1;
   localparam logic START_LEVEL    = 1'b0;
   localparam logic STOP_LEVEL     = 1'b1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_state_t;

   // Expected parity bit for a word; zero-extension does not change the XOR.
   function automatic logic calc_parity(input logic [8:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags its edges.
// The synchronizer resets to the idle level so reset never looks like a start edge.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rx_s,
   output logic rx_fall,
   output logic rx_rise
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rx_d_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= {SYNC_STAGES{IDLE_LEVEL}};
         rx_d_reg <= IDLE_LEVEL;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
         rx_d_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign rx_s    = sync_reg[SYNC_STAGES-1];
   assign rx_fall = rx_d_reg & ~rx_s;
   assign rx_rise = ~rx_d_reg & rx_s;

endmodule

// File: rtl/uart_serial_rx.sv
// UART receiver: mid-bit aligned deserializer with optional parity and stop-bit check.
// Result strobes are registered one cycle after the stop-bit sample.
module uart_serial_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic rx_s, rx_fall, rx_rise;

   uart_rx_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .rx_s    (rx_s),
      .rx_fall (rx_fall),
      .rx_rise (rx_rise)
   );

   logic [2:0]           state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [IW-1:0]        idx_reg, idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_bad_reg, par_bad_next;
   logic                 armed_reg, armed_next;
   logic [DATA_BITS-1:0] dout_next;
   logic                 dv_next, pe_next, fe_next;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg + CW'(1);
      idx_next     = idx_reg;
      shift_next   = shift_reg;
      par_bad_next = par_bad_reg;
      armed_next   = armed_reg | rx_rise;
      dout_next    = data_out;
      dv_next      = 1'b0;
      pe_next      = 1'b0;
      fe_next      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            cnt_next     = '0;
            idx_next     = '0;
            par_bad_next = 1'b0;
            if (rx_fall && armed_reg) begin
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (cnt_reg == CNT_MID) begin
               cnt_next   = '0;
               // A start bit that is high again at mid-bit was a glitch.
               state_next = (rx_s == START_LEVEL) ? ST_DATA : ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next   = '0;
               shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
               idx_next   = idx_reg + IW'(1);
               if (idx_reg == IDX_LAST) begin
                  state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next     = '0;
               par_bad_next = (rx_s != calc_parity(9'(shift_reg), 1'(PARITY_ODD)));
               state_next   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next   = '0;
               state_next = ST_IDLE;
               if (rx_s != STOP_LEVEL) begin
                  // Re-arm only after the line has been seen high again (break handling).
                  fe_next    = 1'b1;
                  armed_next = 1'b0;
               end else if (par_bad_reg) begin
                  pe_next = 1'b1;
               end else begin
                  dv_next   = 1'b1;
                  dout_next = shift_reg;
               end
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         shift_reg   <= '0;
         par_bad_reg <= 1'b0;
         armed_reg   <= 1'b1;
         data_out    <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         shift_reg   <= shift_next;
         par_bad_reg <= par_bad_next;
         armed_reg   <= armed_next;
         data_out    <= dout_next;
         data_valid  <= dv_next;
         parity_err  <= pe_next;
         frame_err   <= fe_next;
      end
   end

   assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_serial_rx.sv
// Directed and random frames into three receiver configurations, checked against a
// frame-level model of the expected outcome (good word, parity error, framing error).
module tb_uart_serial_rx;

   localparam int K_VALID = 1;
   localparam int K_PERR  = 2;
   localparam int K_FERR  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxl  [3];
   logic [7:0] dout [3];
   logic       dv   [3];
   logic       pe   [3];
   logic       fe   [3];
   logic       bsy  [3];

   typedef struct {
      int         inst;
      int         kind;
      logic [7:0] data;
   } ev_t;

   ev_t        ev_q[$];
   int         overlap = 0;
   int         errors  = 0;
   int         checks  = 0;
   logic [7:0] exp_dout [3];

   always #5 clk = ~clk;

   // 8N1, 10 clk/bit
   uart_serial_rx #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
      .clk(clk), .reset(reset), .rx(rxl[0]), .data_out(dout[0]), .data_valid(dv[0]),
      .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));

   // 8E1, 10 clk/bit
   uart_serial_rx #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .clk(clk), .reset(reset), .rx(rxl[1]), .data_out(dout[1]), .data_valid(dv[1]),
      .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));

   // 8N1, 16 clk/bit, used for baud tolerance
   uart_serial_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_f (
      .clk(clk), .reset(reset), .rx(rxl[2]), .data_out(dout[2]), .data_valid(dv[2]),
      .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if ((dv[i] && pe[i]) || (dv[i] && fe[i]) || (pe[i] && fe[i])) overlap++;
         if (dv[i] === 1'b1) ev_q.push_back('{i, K_VALID, dout[i]});
         if (pe[i] === 1'b1) ev_q.push_back('{i, K_PERR, 8'h00});
         if (fe[i] === 1'b1) ev_q.push_back('{i, K_FERR, 8'h00});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serializes one frame; p100 is the bit period in hundredths of a clock.
   task automatic send_frame(input int inst, input logic [7:0] data, input bit par_en,
                             input bit par_bit, input bit stop_bit, input int p100);
      bit bits [12];
      int nb;
      int t0, t1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = data[i];
      nb = 9;
      if (par_en) begin
         bits[nb] = par_bit;
         nb++;
      end
      bits[nb] = stop_bit;
      nb++;
      $display("tx inst=%0d data=%02h par_en=%0b par=%0b stop=%0b period=%0d.%02d",
               inst, data, par_en, par_bit, stop_bit, p100 / 100, p100 % 100);
      for (int k = 0; k < nb; k++) begin
         rxl[inst] = bits[k];
         t0 = (k * p100) / 100;
         t1 = ((k + 1) * p100) / 100;
         tick(t1 - t0);
      end
      rxl[inst] = 1'b1;
   endtask

   // Frame-level model: a low stop bit is a framing error; otherwise the word is good
   // only when data plus parity bit holds an even number of ones.
   function automatic int model_kind(input logic [7:0] data, input bit par_en,
                                     input bit par_bit, input bit stop_bit);
      if (!stop_bit) return K_FERR;
      if (par_en && ((($countones(data) + int'(par_bit)) % 2) != 0)) return K_PERR;
      return K_VALID;
   endfunction

   task automatic expect_event(input string tag, input int inst, input int kind,
                               input logic [7:0] data);
      ev_t ev;
      chk({tag, "_present"}, (ev_q.size() > 0), 1);
      if (ev_q.size() > 0) begin
         ev = ev_q.pop_front();
         chk({tag, "_inst"}, ev.inst, inst);
         chk({tag, "_kind"}, ev.kind, kind);
         if (kind == K_VALID) chk({tag, "_data"}, ev.data, data);
      end
   endtask

   task automatic frame(input string tag, input int inst, input logic [7:0] data,
                        input bit par_en, input bit par_bit, input bit stop_bit, input int p100);
      int kind;
      kind = model_kind(data, par_en, par_bit, stop_bit);
      if (kind == K_VALID) exp_dout[inst] = data;
      send_frame(inst, data, par_en, par_bit, stop_bit, p100);
      tick(4);
      chk({tag, "_count"}, ev_q.size(), 1);
      expect_event(tag, inst, kind, data);
      chk({tag, "_dout"}, dout[inst], exp_dout[inst]);
      chk({tag, "_busy"}, bsy[inst], 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rxl[i] = 1'b1;
         exp_dout[i] = 8'h00;
      end
      reset = 1'b1;
      tick(3);
      for (int i = 0; i < 3; i++) begin
         chk("reset_dout", dout[i], 8'h00);
         chk("reset_busy", bsy[i], 1'b0);
         chk("reset_strobes", {dv[i], pe[i], fe[i]}, 3'b000);
      end
      reset = 1'b0;
      tick(5);

      frame("basic_55", 0, 8'h55, 0, 0, 1, 1000);

      // Short low glitch: receiver starts, rejects at mid-bit, no strobe.
      rxl[0] = 1'b0;
      tick(3);
      rxl[0] = 1'b1;
      tick(2);
      chk("glitch_busy_high", bsy[0], 1'b1);
      tick(10);
      chk("glitch_busy_low", bsy[0], 1'b0);
      chk("glitch_no_event", ev_q.size(), 0);

      frame("stop_low_a3", 0, 8'hA3, 0, 0, 0, 1000);
      tick(5);

      frame("par_bad_07", 1, 8'h07, 1, 0, 1, 1000);
      tick(5);
      frame("par_good_07", 1, 8'h07, 1, 1, 1, 1000);
      tick(5);

      // Back-to-back frames with no idle gap after the stop bit.
      send_frame(0, 8'h01, 0, 0, 1, 1000);
      send_frame(0, 8'h80, 0, 0, 1, 1000);
      send_frame(0, 8'hFF, 0, 0, 1, 1000);
      tick(4);
      chk("b2b_count", ev_q.size(), 3);
      expect_event("b2b_0", 0, K_VALID, 8'h01);
      expect_event("b2b_1", 0, K_VALID, 8'h80);
      expect_event("b2b_2", 0, K_VALID, 8'hFF);
      exp_dout[0] = 8'hFF;
      chk("b2b_dout", dout[0], exp_dout[0]);
      tick(5);

      // Reset in the middle of data bit 4 discards the partial word.
      rxl[0] = 1'b0;
      tick(10);
      for (int k = 0; k < 4; k++) begin
         rxl[0] = k[0];
         tick(10);
      end
      rxl[0] = 1'b1;
      tick(5);
      chk("midreset_busy_before", bsy[0], 1'b1);
      reset = 1'b1;
      tick(2);
      chk("midreset_busy_in_reset", bsy[0], 1'b0);
      chk("midreset_dout_in_reset", dout[0], 8'h00);
      for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;
      reset = 1'b0;
      tick(20);
      chk("midreset_no_event", ev_q.size(), 0);
      chk("midreset_busy_after", bsy[0], 1'b0);
      frame("after_reset_3c", 0, 8'h3C, 0, 0, 1, 1000);
      tick(5);

      // Held-low break line gives a single framing error.
      rxl[0] = 1'b0;
      tick(300);
      chk("break_count", ev_q.size(), 1);
      expect_event("break", 0, K_FERR, 8'h00);
      chk("break_dout", dout[0], exp_dout[0]);
      rxl[0] = 1'b1;
      tick(10);
      chk("break_release_quiet", ev_q.size(), 0);
      frame("after_break_c5", 0, 8'hC5, 0, 0, 1, 1000);
      tick(5);

      for (int n = 0; n < 6; n++) begin
         logic [7:0] d;
         bit         s;
         d = 8'($urandom);
         s = ($urandom_range(0, 3) != 0);
         frame("rand_8n1", 0, d, 0, 0, s, 1000);
         tick(3 + $urandom_range(0, 4));
      end

      for (int n = 0; n < 6; n++) begin
         logic [7:0] d;
         bit         pb;
         d  = 8'($urandom);
         pb = 1'($urandom_range(0, 1));
         frame("rand_8e1", 1, d, 1, pb, 1, 1000);
         tick(3 + $urandom_range(0, 4));
      end

      // Baud tolerance: transmitter 4% fast and 4% slow against a 16 clk/bit receiver.
      frame("nominal_96", 2, 8'h96, 0, 0, 1, 1600);
      tick(5);
      frame("fast_96", 2, 8'h96, 0, 0, 1, 1536);
      tick(5);
      frame("slow_96", 2, 8'h96, 0, 0, 1, 1664);
      tick(5);
      frame("rand_16", 2, 8'($urandom), 0, 0, 1, 1600);
      tick(5);

      chk("strobe_overlap", overlap, 0);
      chk("no_stray_events", ev_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
